ex_ovf_trap_stage: RTL and testbench
====================================

Name: ex_ovf_trap_stage

Overview:
- EX→MEM pipeline register fed directly by the add/sub overflow datapath.
- Performs signed/unsigned add or subtract and registers the result for MEM/WB.
- Converts signed overflow (ADD/SUB only) into a MIPS arithmetic-overflow exception: suppresses the write-back, latches EPC/Cause, and holds a trap request until the exception controller acknowledges.
- Uses valid/ready handshakes upstream and downstream, and keeps a saturating overflow-event counter for debug.

Parameters:
- WIDTH, 32, operand/result width in bits (min 2).
- CNT_W, 8, width of the saturating overflow counter.
- EXC_OV, 5'd12, Cause ExcCode written on overflow trap.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- in_op  in  2  00 ADD, 01 ADDU, 10 SUB, 11 SUBU
- in_a  in  WIDTH  operand A (two's complement)
- in_b  in  WIDTH  operand B
- in_pc  in  32  PC of the instruction
- in_rd  in  5  destination register
- out_valid  out  1  registered result valid
- out_ready  in  1  downstream accepts
- out_result  out  WIDTH  A+B or A−B, mod 2^WIDTH
- out_rd  out  5  destination register
- out_wen  out  1  register write enable (0 when rd==0)
- trap_req  out  1  overflow exception pending
- trap_epc  out  32  PC of the faulting instruction
- trap_cause  out  5  ExcCode
- trap_ack  in  1  exception controller has taken the trap
- ovf_count  out  CNT_W  saturating count of overflow traps

Behaviour:
- Reset (async, rst_n=0): state=RUN; out_valid=0, out_result=0, out_rd=0, out_wen=0, trap_req=0, trap_epc=0, trap_cause=0, ovf_count=0. Reset mid-trap or mid-stall discards everything, with no residual beat.
- States:
  - RUN: normal flow.
  - TRAP: waiting for trap_ack.
- in_ready = (state==RUN) && (!out_valid || out_ready). Combinational; never depends on in_valid.
- Accept = in_valid && in_ready. Latency is one cycle from accept to out_valid.
- Arithmetic:
  - sum = A+B and diff = A−B, both truncated to WIDTH; carry/borrow discarded.
  - ADD overflow = (A[msb]==B[msb]) && (res[msb]!=A[msb]).
  - SUB overflow = (A[msb]!=B[msb]) && (res[msb]!=A[msb]).
  - ADDU/SUBU never overflow.
- Accept without overflow: register result/rd; out_wen = (rd!=0); out_valid=1.
- Accept with overflow:
  - Do not produce an output beat (out_valid falls to 0 if the old beat drains the same cycle).
  - Set trap_req=1, trap_epc=in_pc, trap_cause=EXC_OV.
  - ovf_count += 1, saturating at all-ones.
  - Go to TRAP.
- out_valid holds with stable data while out_valid && !out_ready. It clears on out_ready unless a new beat is accepted the same cycle (back-to-back throughput of 1/cycle).
- TRAP:
  - in_ready=0.
  - A pending out_valid beat (older instruction) still drains normally.
  - trap_req, trap_epc and trap_cause are held stable.
  - trap_ack (sampled only while trap_req=1) → trap_req=0, state=RUN next cycle. in_ready may rise that same next cycle.
  - trap_epc and trap_cause persist until the next trap or reset.
- trap_ack in RUN is ignored.
- Flushing younger instructions upstream is the exception controller's job; this stage only stalls.

Test Plan:
- WIDTH=3, SUB A=1, B=−2 → out_result=3 (3'b011), no trap, out_valid one cycle after accept.
- WIDTH=3, ADD A=3, B=1 → no out_valid; trap_req=1, trap_epc=in_pc, trap_cause=12, ovf_count=1; in_ready=0 until trap_ack, then RUN.
- WIDTH=32, SUB 0x80000000 − 1 → trap. Same operands with SUBU → out_result=0x7FFFFFFF, no trap.
- Back-to-back ADDU beats with out_ready held 0 for 3 cycles → first result stable, in_ready=0; on release, all beats emerge in order with none lost or duplicated.
- rd=0, ADD 5+7 → out_result=12, out_wen=0. ADD overflow while an older beat is stalled → the older beat drains during TRAP.
- Assert rst_n=0 mid-TRAP → all outputs 0 asynchronously. CNT_W=2 with 5 traps → ovf_count saturates at 3.

Source files
------------

// File: rtl/ex_ovf_trap_stage.sv
// EX->MEM pipeline register behind the add/sub datapath. A signed overflow on ADD/SUB
// suppresses write-back and raises a held MIPS overflow trap until it is acknowledged.
module ex_ovf_trap_stage #(
    parameter int         WIDTH  = 32,
    parameter int         CNT_W  = 8,
    parameter logic [4:0] EXC_OV = 5'd12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [31:0]      in_pc,
    input  logic [4:0]       in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [4:0]       out_rd,
    output logic             out_wen,
    output logic             trap_req,
    output logic [31:0]      trap_epc,
    output logic [4:0]       trap_cause,
    input  logic             trap_ack,
    output logic [CNT_W-1:0] ovf_count
);

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             is_sub;
    logic             is_signed;
    logic [WIDTH-1:0] res;
    logic             a_msb;
    logic             b_msb;
    logic             r_msb;
    logic             ovf;
    logic             accept;

    // in_op[1] selects subtract, in_op[0] selects the unsigned (never-trapping) form.
    assign is_sub    = in_op[1];
    assign is_signed = ~in_op[0];
    assign res       = is_sub ? (in_a - in_b) : (in_a + in_b);
    assign a_msb     = in_a[WIDTH-1];
    assign b_msb     = in_b[WIDTH-1];
    assign r_msb     = res[WIDTH-1];
    assign ovf       = is_signed && (r_msb != a_msb) &&
                       (is_sub ? (a_msb != b_msb) : (a_msb == b_msb));

    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign trap_req = (state == TRAP);

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (accept && ovf) state_nxt = TRAP;
            TRAP:    if (trap_ack)      state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // An overflowing beat never lands here; the older beat (if any) still drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= 5'd0;
            out_wen    <= 1'b0;
        end else if (accept && !ovf) begin
            out_valid  <= 1'b1;
            out_result <= res;
            out_rd     <= in_rd;
            out_wen    <= (in_rd != 5'd0);
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // EPC/Cause persist after acknowledge until the next trap or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_epc   <= 32'd0;
            trap_cause <= 5'd0;
            ovf_count  <= '0;
        end else if (accept && ovf) begin
            trap_epc   <= in_pc;
            trap_cause <= EXC_OV;
            if (ovf_count != {CNT_W{1'b1}}) begin
                ovf_count <= ovf_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ex_ovf_trap_stage.sv
// Bench for ex_ovf_trap_stage: a narrow (WIDTH=3, CNT_W=2) and a wide (WIDTH=32) instance,
// each checked every cycle against a scoreboard model built on exact integer arithmetic.
module tb_ex_ovf_trap_stage;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_ADDU = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_SUBU = 2'b11;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wen;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Index 0 drives the WIDTH=3/CNT_W=2 instance, index 1 the WIDTH=32 instance.
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [1:0]  in_op     [2];
    logic [31:0] in_a      [2];
    logic [31:0] in_b      [2];
    logic [31:0] in_pc     [2];
    logic [4:0]  in_rd     [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [4:0]  out_rd    [2];
    logic        out_wen   [2];
    logic        trap_req  [2];
    logic [31:0] trap_epc  [2];
    logic [4:0]  trap_cause[2];
    logic        trap_ack  [2];
    logic [2:0]  res3;
    logic [31:0] res32;
    logic [1:0]  cnt3;
    logic [7:0]  cnt32;

    int total = 0;
    int bad   = 0;

    ex_ovf_trap_stage #(.WIDTH(3), .CNT_W(2), .EXC_OV(5'd12)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_op(in_op[0]),
        .in_a(in_a[0][2:0]), .in_b(in_b[0][2:0]), .in_pc(in_pc[0]), .in_rd(in_rd[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_result(res3),
        .out_rd(out_rd[0]), .out_wen(out_wen[0]),
        .trap_req(trap_req[0]), .trap_epc(trap_epc[0]), .trap_cause(trap_cause[0]),
        .trap_ack(trap_ack[0]), .ovf_count(cnt3)
    );

    ex_ovf_trap_stage #(.WIDTH(32), .CNT_W(8), .EXC_OV(5'd12)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_op(in_op[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .in_pc(in_pc[1]), .in_rd(in_rd[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_result(res32),
        .out_rd(out_rd[1]), .out_wen(out_wen[1]),
        .trap_req(trap_req[1]), .trap_epc(trap_epc[1]), .trap_cause(trap_cause[1]),
        .trap_ack(trap_ack[1]), .ovf_count(cnt32)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Exact arithmetic on sign-extended integers; overflow means the true value leaves the range.
    function automatic void model_alu(input int w, input logic [1:0] op,
                                      input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output bit ovf);
        longint one, m, half, sa, sb, t;
        one  = 1;
        m    = (one << w) - 1;
        half = one << (w - 1);
        sa   = 0;
        sb   = 0;
        sa[31:0] = a;
        sb[31:0] = b;
        sa   = sa & m;
        sb   = sb & m;
        if (sa >= half) sa = sa - (one << w);
        if (sb >= half) sb = sb - (one << w);
        t    = op[1] ? (sa - sb) : (sa + sb);
        ovf  = (op[0] == 1'b0) && ((t < -half) || (t >= half));
        t    = t & m;
        r    = t[31:0];
    endfunction

    beat_t       exp_q   [2][$];
    bit          m_trap  [2];
    logic [31:0] m_epc   [2];
    logic [4:0]  m_cause [2];
    int          m_cnt   [2];

    // Scoreboard: check current outputs, then advance the model by what the next edge will do.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [31:0] ares, acnt, r;
            bit          exp_ready, fire, acc, ovf;
            beat_t       b;
            ares = (i == 0) ? {29'd0, res3} : res32;
            acnt = (i == 0) ? {30'd0, cnt3} : {24'd0, cnt32};
            if (!rst_n) begin
                exp_q[i].delete();
                m_trap[i]  = 1'b0;
                m_epc[i]   = 32'd0;
                m_cause[i] = 5'd0;
                m_cnt[i]   = 0;
            end else begin
                exp_ready = !m_trap[i] && ((exp_q[i].size() == 0) || out_ready[i]);
                check($sformatf("d%0d.in_ready", i), {31'd0, in_ready[i]}, {31'd0, exp_ready});
                check($sformatf("d%0d.out_valid", i), {31'd0, out_valid[i]},
                      {31'd0, exp_q[i].size() != 0});
                check($sformatf("d%0d.trap_req", i), {31'd0, trap_req[i]}, {31'd0, m_trap[i]});
                check($sformatf("d%0d.trap_epc", i), trap_epc[i], m_epc[i]);
                check($sformatf("d%0d.trap_cause", i), {27'd0, trap_cause[i]}, {27'd0, m_cause[i]});
                check($sformatf("d%0d.ovf_count", i), acnt, m_cnt[i]);
                if (exp_q[i].size() != 0) begin
                    check($sformatf("d%0d.out_result", i), ares, exp_q[i][0].res);
                    check($sformatf("d%0d.out_rd", i), {27'd0, out_rd[i]}, {27'd0, exp_q[i][0].rd});
                    check($sformatf("d%0d.out_wen", i), {31'd0, out_wen[i]}, {31'd0, exp_q[i][0].wen});
                end
                fire = (exp_q[i].size() != 0) && out_ready[i];
                acc  = in_valid[i] && exp_ready;
                if (m_trap[i] && trap_ack[i]) m_trap[i] = 1'b0;
                if (fire) void'(exp_q[i].pop_front());
                if (acc) begin
                    model_alu((i == 0) ? 3 : 32, in_op[i], in_a[i], in_b[i], r, ovf);
                    if (ovf) begin
                        m_trap[i]  = 1'b1;
                        m_epc[i]   = in_pc[i];
                        m_cause[i] = 5'd12;
                        if (m_cnt[i] < ((i == 0) ? 3 : 255)) m_cnt[i]++;
                    end else begin
                        b.res = r;
                        b.rd  = in_rd[i];
                        b.wen = (in_rd[i] != 5'd0);
                        exp_q[i].push_back(b);
                    end
                end
            end
        end
    end

    // Entered and left at posedge+1; the beat is accepted on the last posedge waited for.
    task automatic send(input int i, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc, input logic [4:0] rd);
        bit ok;
        ok          = 1'b0;
        in_op[i]    = op;
        in_a[i]     = a;
        in_b[i]     = b;
        in_pc[i]    = pc;
        in_rd[i]    = rd;
        in_valid[i] = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready[i]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic ack(input int i);
        trap_ack[i] = 1'b1;
        @(posedge clk);
        #1;
        trap_ack[i] = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            in_op[i]     = OP_ADD;
            in_a[i]      = 32'd0;
            in_b[i]      = 32'd0;
            in_pc[i]     = 32'd0;
            in_rd[i]     = 5'd0;
            out_ready[i] = 1'b1;
            trap_ack[i]  = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst.out_valid", {31'd0, out_valid[i]}, 32'd0);
            check("rst.trap_req", {31'd0, trap_req[i]}, 32'd0);
            check("rst.trap_epc", trap_epc[i], 32'd0);
            check("rst.out_wen", {31'd0, out_wen[i]}, 32'd0);
        end
        check("rst.res32", res32, 32'd0);
        check("rst.cnt32", {24'd0, cnt32}, 32'd0);
        rst_n = 1'b1;
        step();

        // WIDTH=3: 1 - (-2) = 3 fits, one-cycle latency.
        send(0, OP_SUB, 32'd1, -32'sd2, 32'h100, 5'd1);
        check("sub3.valid", {31'd0, out_valid[0]}, 32'd1);
        check("sub3.result", {29'd0, res3}, 32'd3);
        step();
        check("sub3.drained", {31'd0, out_valid[0]}, 32'd0);

        // WIDTH=3: 3 + 1 overflows.
        send(0, OP_ADD, 32'd3, 32'd1, 32'h104, 5'd2);
        check("ovf3.valid", {31'd0, out_valid[0]}, 32'd0);
        check("ovf3.req", {31'd0, trap_req[0]}, 32'd1);
        check("ovf3.epc", trap_epc[0], 32'h104);
        check("ovf3.cause", {27'd0, trap_cause[0]}, 32'd12);
        check("ovf3.cnt", {30'd0, cnt3}, 32'd1);
        step();
        step();
        check("ovf3.stall", {31'd0, in_ready[0]}, 32'd0);
        ack(0);
        check("ovf3.ack_req", {31'd0, trap_req[0]}, 32'd0);
        check("ovf3.ack_ready", {31'd0, in_ready[0]}, 32'd1);
        check("ovf3.epc_kept", trap_epc[0], 32'h104);

        // WIDTH=32: SUB traps, SUBU wraps to 0x7FFFFFFF.
        send(1, OP_SUB, 32'h8000_0000, 32'd1, 32'h200, 5'd3);
        check("sub32.req", {31'd0, trap_req[1]}, 32'd1);
        check("sub32.epc", trap_epc[1], 32'h200);
        ack(1);
        send(1, OP_SUBU, 32'h8000_0000, 32'd1, 32'h204, 5'd3);
        check("subu32.result", res32, 32'h7FFF_FFFF);
        check("subu32.req", {31'd0, trap_req[1]}, 32'd0);
        step();

        // trap_ack outside TRAP is ignored.
        ack(1);
        check("ack_run.req", {31'd0, trap_req[1]}, 32'd0);

        // Back-to-back ADDU with a 3-cycle downstream stall.
        out_ready[1] = 1'b0;
        send(1, OP_ADDU, 32'd10, 32'd20, 32'h210, 5'd5);
        in_op[1] = OP_ADDU; in_a[1] = 32'd100; in_b[1] = 32'd1; in_rd[1] = 5'd6;
        in_valid[1] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            check("b2b.stall_ready", {31'd0, in_ready[1]}, 32'd0);
            check("b2b.stable", res32, 32'd30);
            step();
        end
        out_ready[1] = 1'b1;
        step();
        check("b2b.second", res32, 32'd101);
        in_a[1] = 32'd7; in_b[1] = 32'd8; in_rd[1] = 5'd7;
        step();
        in_valid[1] = 1'b0;
        check("b2b.third", res32, 32'd15);
        step();
        check("b2b.empty", {31'd0, out_valid[1]}, 32'd0);

        // rd=0 suppresses write enable.
        send(1, OP_ADD, 32'd5, 32'd7, 32'h220, 5'd0);
        check("rd0.result", res32, 32'd12);
        check("rd0.wen", {31'd0, out_wen[1]}, 32'd0);
        step();

        // Overflow beat accepted on the edge that drains a stalled older beat.
        out_ready[1] = 1'b0;
        send(1, OP_ADDU, 32'd1, 32'd2, 32'h230, 5'd4);
        in_op[1] = OP_ADD; in_a[1] = 32'h7FFF_FFFF; in_b[1] = 32'd1; in_pc[1] = 32'h300;
        in_valid[1] = 1'b1;
        step();
        step();
        check("drain.held", res32, 32'd3);
        out_ready[1] = 1'b1;
        step();
        in_valid[1] = 1'b0;
        check("drain.valid", {31'd0, out_valid[1]}, 32'd0);
        check("drain.req", {31'd0, trap_req[1]}, 32'd1);
        check("drain.epc", trap_epc[1], 32'h300);
        check("drain.cnt", {24'd0, cnt32}, 32'd2);
        ack(1);

        // Asynchronous reset in the middle of a trap.
        send(0, OP_ADD, 32'd3, 32'd1, 32'h108, 5'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.req", {31'd0, trap_req[0]}, 32'd0);
        check("arst.epc", trap_epc[0], 32'd0);
        check("arst.cause", {27'd0, trap_cause[0]}, 32'd0);
        check("arst.cnt", {30'd0, cnt3}, 32'd0);
        check("arst.res", {29'd0, res3}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // CNT_W=2: five traps saturate at 3.
        for (int k = 1; k <= 5; k++) begin
            logic [31:0] av, bv;
            logic [1:0]  op;
            case (k)
                1: begin op = OP_ADD; av = 32'd3;   bv = 32'd1;   end
                2: begin op = OP_ADD; av = -32'sd4; bv = -32'sd1; end
                3: begin op = OP_SUB; av = 32'd3;   bv = -32'sd1; end
                4: begin op = OP_SUB; av = -32'sd4; bv = 32'd1;   end
                default: begin op = OP_ADD; av = 32'd2; bv = 32'd2; end
            endcase
            send(0, op, av, bv, 32'h400 + 32'(k), 5'd1);
            check($sformatf("sat.cnt%0d", k), {30'd0, cnt3}, (k < 3) ? k : 3);
            ack(0);
        end

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
